// File: rtl/dht11_pkg.sv
// rtl/dht11_pkg.sv - shared states, error codes and frame helpers for the DHT11 host
package dht11_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START_LO,
    ST_RELEASE,
    ST_RESP_LO,
    ST_RESP_HI,
    ST_BIT_LO,
    ST_BIT_HI,
    ST_CHECK,
    ST_ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_NORESP  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_CSUM    = 2'd3;

  localparam int FRAME_BITS = 40;

  // Byte 4 of a frame is the mod-256 sum of bytes 0..3.
  function automatic logic [7:0] frame_csum(input logic [FRAME_BITS-1:0] f);
    return f[39:32] + f[31:24] + f[23:16] + f[15:8];
  endfunction

  function automatic logic is_timed(input state_e s);
    return (s == ST_START_LO) || (s == ST_RELEASE) || (s == ST_RESP_LO) ||
           (s == ST_RESP_HI)  || (s == ST_BIT_LO)  || (s == ST_BIT_HI);
  endfunction

endpackage

// File: rtl/dht11_line_sync.sv
// rtl/dht11_line_sync.sv - two-flop synchronizer with edge detect for the DHT11 line
module dht11_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic line_s,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[0], line_i};
    prev_d = sync_q[1];
  end

  // Reset to the pulled-up idle level so no edge is seen on reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign line_s = sync_q[1];
  assign rise   = sync_q[1] & ~prev_q;
  assign fall   = ~sync_q[1] & prev_q;

endmodule

// File: rtl/dht11_host.sv
// rtl/dht11_host.sv - DHT11 single-wire bus master: start pulse, preamble check, 40-bit read, checksum
module dht11_host
  import dht11_pkg::*;
#(
  parameter int START_LOW_CYCLES  = 18000,
  parameter int BIT_THRESH_CYCLES = 48,
  parameter int TIMEOUT_CYCLES    = 200,
  parameter int CNT_W             = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  inout  wire        data_io,
  output logic       busy_o,
  output logic       valid_o,
  output logic       error_o,
  output logic [1:0] err_code_o,
  output logic [7:0] hum_int_o,
  output logic [7:0] hum_dec_o,
  output logic [7:0] temp_int_o,
  output logic [7:0] temp_dec_o
);

  localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] THRESH_C     = CNT_W'(BIT_THRESH_CYCLES);
  localparam logic [5:0]       LAST_IDX     = 6'(FRAME_BITS - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [5:0]              idx_q, idx_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic                    busy_q, busy_d;
  logic                    valid_q, valid_d;
  logic                    error_q, error_d;
  logic [1:0]              err_code_q, err_code_d;
  logic [31:0]             data_q, data_d;

  logic line_s, rise, fall;
  logic timeout;
  logic bit_val;

  dht11_line_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .line_i (data_io),
    .line_s (line_s),
    .rise   (rise),
    .fall   (fall)
  );

  // Only ever pull low; the line is released the instant state leaves START_LO.
  assign data_io = (state_q == ST_START_LO) ? 1'b0 : 1'bz;

  assign timeout = (cnt_q == TIMEOUT_LAST);
  // The counter lags the true high width by one cycle, so >= decodes widths above threshold.
  assign bit_val = (cnt_q >= THRESH_C);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    error_d    = 1'b0;
    err_code_d = err_code_q;
    data_d     = data_q;

    case (state_q)
      ST_IDLE: begin
        // The pulse cycle after a frame still counts as busy for new requests.
        if (start_i && !valid_q && !error_q) begin
          state_d    = ST_START_LO;
          busy_d     = 1'b1;
          err_code_d = ERR_NONE;
        end
      end
      ST_START_LO: begin
        if (cnt_q == START_LAST) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (fall) begin
          state_d = ST_RESP_LO;
        end else if (timeout) begin
          state_d    = ST_ERROR;
          err_code_d = ERR_NORESP;
        end
      end
      ST_RESP_LO: begin
        if (rise) begin
          state_d = ST_RESP_HI;
        end else if (timeout) begin
          state_d    = ST_ERROR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      ST_RESP_HI: begin
        if (fall) begin
          state_d = ST_BIT_LO;
          idx_d   = '0;
        end else if (timeout) begin
          state_d    = ST_ERROR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      ST_BIT_LO: begin
        if (rise) begin
          state_d = ST_BIT_HI;
        end else if (timeout) begin
          state_d    = ST_ERROR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      ST_BIT_HI: begin
        if (fall) begin
          shift_d = {shift_q[FRAME_BITS-2:0], bit_val};
          if (idx_q == LAST_IDX) begin
            state_d = ST_CHECK;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = ST_BIT_LO;
          end
        end else if (timeout) begin
          state_d    = ST_ERROR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      ST_CHECK: begin
        if (frame_csum(shift_q) == shift_q[7:0]) begin
          data_d  = shift_q[39:8];
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d    = ST_ERROR;
          err_code_d = ERR_CSUM;
        end
      end
      ST_ERROR: begin
        error_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (is_timed(state_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      data_q     <= data_d;
    end
  end

  assign busy_o     = busy_q;
  assign valid_o    = valid_q;
  assign error_o    = error_q;
  assign err_code_o = err_code_q;
  assign hum_int_o  = data_q[31:24];
  assign hum_dec_o  = data_q[23:16];
  assign temp_int_o = data_q[15:8];
  assign temp_dec_o = data_q[7:0];

endmodule

// File: tb/tb_dht11_host.sv
// tb/tb_dht11_host.sv - randomized bench for dht11_host with a behavioural sensor and frame model
module tb_dht11_host;

  localparam int START_LOW = 300;
  localparam int THRESH    = 48;
  localparam int TMO       = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0;
  logic sens_low = 1'b0;
  wire  bus_line;

  logic       busy_o, valid_o, error_o;
  logic [1:0] err_code_o;
  logic [7:0] hum_int_o, hum_dec_o, temp_int_o, temp_dec_o;

  pullup (bus_line);
  assign bus_line = sens_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  dht11_host #(
    .START_LOW_CYCLES  (START_LOW),
    .BIT_THRESH_CYCLES (THRESH),
    .TIMEOUT_CYCLES    (TMO),
    .CNT_W             (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .data_io    (bus_line),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .error_o    (error_o),
    .err_code_o (err_code_o),
    .hum_int_o  (hum_int_o),
    .hum_dec_o  (hum_dec_o),
    .temp_int_o (temp_int_o),
    .temp_dec_o (temp_dec_o)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_miss = 0;
  int bit_w[40];
  int sp_mode = 0;
  int sp_bit = 99;
  int low_len, rel_cyc, freeze_cyc, start_cyc;
  logic [31:0] model_last = '0;

  int both_hi = 0, busy_bad = 0, n_valid = 0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (valid_o && error_o) both_hi <= both_hi + 1;
      if (valid_o) n_valid <= n_valid + 1;
      if ((valid_o || error_o) && busy_o) busy_bad <= busy_bad + 1;
      if (prev_busy && !busy_o && !(valid_o || error_o)) busy_bad <= busy_bad + 1;
    end
    prev_busy <= busy_o;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic hold(input bit lo, input int n);
    sens_low = lo;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    start_cyc = cyc;
  endtask

  // Sensor: measure the host start pulse, answer with preamble and 40 bits of given high widths.
  task automatic sensor_run();
    int g;
    g = 0;
    while (bus_line !== 1'b0 && g < 200) begin @(posedge clk); #1; g++; end
    low_len = 0;
    while (bus_line === 1'b0 && low_len < 4 * START_LOW) begin
      low_len++;
      @(posedge clk); #1;
    end
    rel_cyc = cyc;
    if (sp_mode == 3) return;
    hold(0, 20);
    hold(1, 80);
    hold(0, 80);
    for (int i = 0; i < 40; i++) begin
      hold(1, 50);
      if (i == sp_bit && sp_mode == 1) begin
        sens_low = 1'b0;
        freeze_cyc = cyc;
        hold(0, 400);
        return;
      end
      if (i == sp_bit && sp_mode == 2) begin
        hold(0, 20);
        #2;
        rst = 1'b1;
        return;
      end
      hold(0, bit_w[i]);
    end
    hold(1, 50);
    sens_low = 1'b0;
  endtask

  task automatic wait_result(input int budget, output bit gv, output bit ge, output int at);
    gv = 1'b0; ge = 1'b0; at = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (rst) return;
      if (valid_o || error_o) begin
        gv = valid_o; ge = error_o; at = cyc;
        return;
      end
    end
  endtask

  task automatic run_frame(input bit mid_start, input bit ret_start,
                           output bit gv, output bit ge, output int at);
    fork
      sensor_run();
      begin
        pulse_start();
        chk("busy_on_start", busy_o, 1'b1);
        if (mid_start) begin
          wait_cyc(1000);
          pulse_start();
        end
        wait_result(20000, gv, ge, at);
        if (ret_start) begin
          start_i = 1'b1;
          @(posedge clk); #1;
          start_i = 1'b0;
          @(negedge clk);
          chk("start_at_return_ignored", busy_o, 1'b0);
        end
      end
    join
  endtask

  // mode 0: nominal widths, 1: threshold-edge widths, 2: random among both
  task automatic set_frame(input logic [39:0] f, input int mode);
    for (int i = 0; i < 40; i++) begin
      bit b;
      bit pick;
      b = f[39 - i];
      pick = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (b) bit_w[i] = pick ? THRESH + 1 : 70;
      else   bit_w[i] = pick ? THRESH : 26;
    end
  endtask

  function automatic logic [39:0] rand_frame(input bit good);
    logic [7:0] b0, b1, b2, b3, s;
    b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
    s = (9'(b0) + 9'(b1) + 9'(b2) + 9'(b3)) % 256;
    if (!good) s = s ^ (8'd1 << $urandom_range(0, 7));
    return {b0, b1, b2, b3, s};
  endfunction

  // Reference: decode widths (> threshold is a 1), checksum is mod-256 sum of the first four bytes.
  task automatic check_model(input string tag, input bit gv, input bit ge);
    logic [39:0] f;
    int sum;
    f = '0;
    for (int i = 0; i < 40; i++) f = {f[38:0], (bit_w[i] > THRESH)};
    sum = (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
    if (sum == int'(f[7:0])) begin
      chk({tag, "_valid"}, gv, 1'b1);
      chk({tag, "_noerr"}, ge, 1'b0);
      chk({tag, "_code"}, err_code_o, 2'd0);
      model_last = f[39:8];
    end else begin
      chk({tag, "_error"}, ge, 1'b1);
      chk({tag, "_novalid"}, gv, 1'b0);
      chk({tag, "_code"}, err_code_o, 2'd3);
    end
    chk({tag, "_data"}, {hum_int_o, hum_dec_o, temp_int_o, temp_dec_o}, model_last);
    chk({tag, "_busy"}, busy_o, 1'b0);
  endtask

  initial begin
    bit gv, ge;
    int at, nv0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_error", error_o, 1'b0);
    chk("rst_code", err_code_o, 2'd0);
    chk("rst_data", {hum_int_o, hum_dec_o, temp_int_o, temp_dec_o}, 32'd0);
    chk("rst_line", bus_line, 1'b1);
    rst = 1'b0;
    wait_cyc(5);

    set_frame(40'h35_00_18_00_4D, 0);
    run_frame(0, 0, gv, ge, at);
    chk("start_low_len", low_len, START_LOW);
    check_model("good", gv, ge);
    chk("good_hum_int", hum_int_o, 8'd53);
    chk("good_temp_int", temp_int_o, 8'd24);
    @(negedge clk);
    chk("valid_one_cycle", valid_o, 1'b0);
    wait_cyc(60);

    set_frame(40'h35_00_18_00_4C, 0);
    run_frame(0, 0, gv, ge, at);
    check_model("badsum", gv, ge);
    chk("badsum_hum_kept", hum_int_o, 8'd53);
    wait_cyc(60);
    chk("code_held", err_code_o, 2'd3);

    set_frame({8'hA5, 8'h5A, 8'h0F, 8'hF0, 8'hFE}, 1);
    run_frame(0, 0, gv, ge, at);
    check_model("thresh", gv, ge);
    chk("thresh_hum_int", hum_int_o, 8'hA5);
    wait_cyc(60);

    for (int k = 0; k < 5; k++) begin
      set_frame(rand_frame(1'($urandom_range(0, 1))), 2);
      run_frame(0, 0, gv, ge, at);
      check_model("rnd", gv, ge);
      wait_cyc(60);
    end

    nv0 = n_valid;
    set_frame(rand_frame(1'b1), 2);
    run_frame(1, 1, gv, ge, at);
    check_model("midstart", gv, ge);
    wait_cyc(300);
    chk("no_restart_busy", busy_o, 1'b0);
    chk("no_restart_line", bus_line, 1'b1);
    chk("single_valid", n_valid - nv0, 1);

    sp_mode = 3;
    run_frame(0, 0, gv, ge, at);
    chk("noresp_low_len", low_len, START_LOW);
    chk("noresp_error", ge, 1'b1);
    chk("noresp_code", err_code_o, 2'd1);
    chk("noresp_time", ((at - start_cyc) >= START_LOW + TMO) && ((at - start_cyc) <= START_LOW + TMO + 6), 1'b1);
    chk("noresp_data", {hum_int_o, hum_dec_o, temp_int_o, temp_dec_o}, model_last);
    wait_cyc(60);

    sp_mode = 1; sp_bit = 17;
    set_frame(rand_frame(1'b1), 0);
    run_frame(0, 0, gv, ge, at);
    chk("freeze_error", ge, 1'b1);
    chk("freeze_code", err_code_o, 2'd2);
    chk("freeze_time", ((at - freeze_cyc) >= TMO) && ((at - freeze_cyc) <= TMO + 8), 1'b1);
    chk("freeze_data", {hum_int_o, hum_dec_o, temp_int_o, temp_dec_o}, model_last);
    chk("freeze_line", bus_line, 1'b1);
    wait_cyc(60);

    sp_mode = 2; sp_bit = 12;
    set_frame(rand_frame(1'b1), 0);
    run_frame(0, 0, gv, ge, at);
    #1;
    chk("bitrst_busy", busy_o, 1'b0);
    chk("bitrst_flags", {valid_o, error_o, err_code_o}, 4'd0);
    chk("bitrst_data", {hum_int_o, hum_dec_o, temp_int_o, temp_dec_o}, 32'd0);
    model_last = '0;
    wait_cyc(3);
    rst = 1'b0;
    sp_mode = 0; sp_bit = 99;
    wait_cyc(60);

    pulse_start();
    wait_cyc(50);
    chk("startlo_drive", bus_line, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_release_line", bus_line, 1'b1);
    chk("rst_release_busy", busy_o, 1'b0);
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(10);

    set_frame(rand_frame(1'b1), 2);
    run_frame(0, 0, gv, ge, at);
    check_model("recover", gv, ge);
    wait_cyc(60);

    chk("valid_error_exclusive", both_hi, 0);
    chk("busy_sequencing", busy_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dht11_host.md
Name: dht11_host

Overview:
- Single-wire bus master for the DHT11 humidity/temperature sensor. It is the upstream stage that drives the `dht11` sensor model's `data_io` line.
- On a start request it:
  - issues the host start pulse,
  - checks the sensor's response preamble,
  - samples the 40 data bits by measuring high-pulse width,
  - verifies the checksum and presents humidity and temperature to system logic.
- The bus is open-drain: the block only ever drives 0 or releases to Z. An external pullup sits on the line.

Parameters:
- START_LOW_CYCLES, 18000: clk cycles the host holds the line low for the start pulse (18 ms at 1 MHz).
- BIT_THRESH_CYCLES, 48: a data-bit high pulse longer than this many cycles decodes as 1; otherwise 0.
- TIMEOUT_CYCLES, 200: maximum cycles allowed in any wait-for-edge state before an error is raised.
- CNT_W, 16: width of the shared cycle counter. Must hold START_LOW_CYCLES.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start_i  input  1  single-cycle request to begin a read. Ignored while busy_o=1.
- data_io  inout  1  open-drain DHT11 line: driven 0 or Z, never driven 1
- busy_o  output  1  high from accepted start until done/error
- valid_o  output  1  one-cycle pulse: frame received with good checksum
- error_o  output  1  one-cycle pulse: frame aborted or checksum bad
- err_code_o  output  2  0 = none, 1 = no response, 2 = bit/preamble timeout, 3 = checksum mismatch. Held until next start.
- hum_int_o  output  8  humidity integer byte
- hum_dec_o  output  8  humidity decimal byte
- temp_int_o  output  8  temperature integer byte
- temp_dec_o  output  8  temperature decimal byte

Behaviour:
- Reset (asynchronous): state=IDLE, data_io released (Z), counter=0, shift register=0. All outputs 0.
- Reset mid-frame releases the line immediately; no partial data reaches the outputs.
- Line input passes through a 2-FF synchronizer. All edge decisions use the synchronized value, giving 2 cycles of input latency.
- Counter clears on every state transition and increments each cycle in timed states.
- States:
  - IDLE: line Z. On start_i: busy_o=1, err_code_o=0 → START_LO.
  - START_LO: drive 0. When counter == START_LOW_CYCLES-1 → RELEASE.
  - RELEASE: line Z; wait for sensor to pull low → RESP_LO. If counter reaches TIMEOUT_CYCLES → ERROR, code 1.
  - RESP_LO: wait for line high → RESP_HI. Timeout → ERROR, code 2.
  - RESP_HI: wait for line low → BIT_LO, bit index=0. Timeout → ERROR, code 2.
  - BIT_LO: wait for line high → BIT_HI. Timeout → ERROR, code 2.
  - BIT_HI: count cycles while line is high. On falling edge, shift in (counter > BIT_THRESH_CYCLES), MSB first.
    - If index == 39 → CHECK; else index+1 → BIT_LO.
    - Timeout → ERROR, code 2.
  - CHECK (1 cycle): sum of bytes 0..3, truncated to 8 bits (mod 256), compared with byte 4.
    - Match: load the four output bytes, valid_o=1 → IDLE.
    - Mismatch → ERROR, code 3.
  - ERROR (1 cycle): error_o=1, err_code_o set → IDLE.
- Output timing and ownership:
  - busy_o drops in the same cycle valid_o or error_o pulses.
  - valid_o and error_o are never high together.
  - Data outputs hold the last good frame; they are unchanged on error.
- Frame timing: the final (40th) bit's falling edge is detected 2 cycles after the bus edge; CHECK follows on the next cycle.
- start_i during busy: ignored, no queuing.
- start_i on the same cycle as the return to IDLE: ignored; accepted from the next cycle.

Decomposition:
- Package dht11_pkg:
  - state enum,
  - err_code constants (ERR_NONE, ERR_NORESP, ERR_TIMEOUT, ERR_CSUM),
  - FRAME_BITS=40.
- Sub-module dht11_line_sync: 2-FF synchronizer plus registered previous value. Outputs line_s, rise, fall.

Test Plan:
- Sensor model answers with bytes 0x35,0x00,0x18,0x00,0x4D after start_i → busy_o high throughout; valid_o single pulse; hum_int_o=53, temp_int_o=24, decimal bytes 0, err_code_o=0.
- Same frame with checksum byte 0x4C → error_o pulse, err_code_o=3, outputs retain previous values.
- No sensor (line held high by pullup) → line low for exactly START_LOW_CYCLES, then error_o at START_LOW_CYCLES + TIMEOUT_CYCLES (± sync latency), code 1.
- Sensor freezes line high during bit 17 → error_o after TIMEOUT_CYCLES, code 2, line released.
- Bits with high widths BIT_THRESH_CYCLES and BIT_THRESH_CYCLES+1 → decoded as 0 and 1 respectively.
- Assert rst during BIT_HI, and separately pulse start_i while busy → line Z in the same cycle as rst, all outputs 0; the mid-frame start_i causes no restart and no extra valid_o.
